// File: rtl/braille_pkg.sv
// rtl/braille_pkg.sv - Shared constants, state encoding and sizing helper for the Braille round controller
package braille_pkg;

    localparam int LETTER_W = 4;

    localparam int DEF_ROUNDS      = 10;
    localparam int DEF_MAX_TRIES   = 3;
    localparam int DEF_TIMEOUT_CYC = 500000;
    localparam int DEF_CHECK_WIN   = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_IN,
        CHECK,
        MISS,
        NEXT,
        DONE
    } state_t;

    // One down-counter serves both the entry timeout and the check window,
    // so it must hold the larger of the two load values.
    function automatic int timer_width(input int timeout_cyc, input int check_win);
        int biggest;
        biggest = (timeout_cyc > check_win) ? timeout_cyc : check_win;
        return (biggest < 2) ? 1 : $clog2(biggest + 1);
    endfunction

endpackage

// File: rtl/braille_entry_timer.sv
// rtl/braille_entry_timer.sv - Loadable down-counter with an expiry flag
//   clk, rst  : clock, synchronous active-low reset
//   load      : load load_val this cycle (wins over counting)
//   load_val  : value to count down from
//   en        : decrement while non-zero
//   expired   : count has reached zero
module braille_entry_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/braille_round_ctrl.sv
// rtl/braille_round_ctrl.sv - Round sequencer for the Braille trainer game
//   clk, rst                      : clock, synchronous active-low reset
//   start                         : level, begins a game from IDLE or DONE
//   rng_req, rng_ack, rng_letter  : random-letter fetch handshake
//   player_valid                  : player entry pulse
//   target, cmp_valid, match_pulse: comparator interface
//   seg_en, score, round_no       : display enable and game status
//   tries_left                    : wrong entries still allowed this round
//   hit, miss, game_over          : round and game events
//   hint                          : low-tries hint when BRAILLE_HINT_EN is defined, else 0
module braille_round_ctrl
    import braille_pkg::*;
#(
    parameter int ROUNDS      = DEF_ROUNDS,
    parameter int MAX_TRIES   = DEF_MAX_TRIES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CHECK_WIN   = DEF_CHECK_WIN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                rng_req,
    input  logic                rng_ack,
    input  logic [LETTER_W-1:0] rng_letter,
    input  logic                player_valid,
    output logic [LETTER_W-1:0] target,
    output logic                cmp_valid,
    input  logic                match_pulse,
    output logic                seg_en,
    output logic [7:0]          score,
    output logic [7:0]          round_no,
    output logic [2:0]          tries_left,
    output logic                hit,
    output logic                miss,
    output logic                game_over,
    output logic                hint
);

    localparam int TW = timer_width(TIMEOUT_CYC, CHECK_WIN);

    // Entry timer is loaded with TIMEOUT_CYC-1 so it reads zero in the
    // TIMEOUT_CYC-th WAIT_IN cycle; the window is loaded with CHECK_WIN so a
    // match is still accepted CHECK_WIN cycles after the cmp_valid cycle.
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] WIN_LOAD = TW'(CHECK_WIN);
    localparam logic [7:0]    ROUNDS_V = 8'(ROUNDS);
    localparam logic [2:0]    TRIES_V  = 3'(MAX_TRIES);

    state_t          state;
    state_t          state_n;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_en;
    logic            tmr_expired;

    braille_entry_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    assign tmr_en = (state == WAIT_IN) || (state == CHECK);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_val  = TO_LOAD;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (rng_ack) begin
                    state_n  = WAIT_IN;
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
                end
            end
            WAIT_IN: begin
                // An entry arriving in the timeout cycle still counts as an entry.
                if (player_valid) begin
                    state_n  = CHECK;
                    tmr_load = 1'b1;
                    tmr_val  = WIN_LOAD;
                end else if (tmr_expired) begin
                    state_n = MISS;
                end
            end
            CHECK: begin
                if (match_pulse) begin
                    state_n = NEXT;
                end else if (tmr_expired) begin
                    state_n = MISS;
                end
            end
            MISS: begin
                if (tries_left <= 3'd1) begin
                    state_n = NEXT;
                end else begin
                    state_n  = WAIT_IN;
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
                end
            end
            NEXT: begin
                state_n = (round_no == ROUNDS_V) ? DONE : FETCH;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rng_req    <= 1'b0;
            cmp_valid  <= 1'b0;
            target     <= '0;
            score      <= '0;
            round_no   <= '0;
            tries_left <= '0;
        end else begin
            // Request only on the way into FETCH, so it lasts a single cycle
            // however long the generator takes to answer.
            rng_req   <= (state_n == FETCH) && (state != FETCH);
            cmp_valid <= (state == WAIT_IN) && player_valid;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        score    <= '0;
                        round_no <= 8'd1;
                    end
                end
                FETCH: begin
                    if (rng_ack) begin
                        target     <= rng_letter;
                        tries_left <= TRIES_V;
                    end
                end
                CHECK: begin
                    if (match_pulse && (score != 8'hFF)) begin
                        score <= score + 8'd1;
                    end
                end
                MISS: begin
                    tries_left <= tries_left - 3'd1;
                end
                NEXT: begin
                    if (round_no != ROUNDS_V) begin
                        round_no <= round_no + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // hit is taken straight from the comparator pulse so the next letter
    // request lands two cycles later (NEXT, then FETCH). Both event pulses
    // are masked during reset so an abandoned game reports nothing.
    assign hit       = rst && (state == CHECK) && match_pulse;
    assign miss      = rst && (state == MISS);
    assign game_over = (state == DONE);
    assign seg_en    = (state != IDLE);

`ifdef BRAILLE_HINT_EN
    assign hint = ((state == WAIT_IN) || (state == CHECK)) && (tries_left == 3'd1);
`else
    assign hint = 1'b0;
`endif

endmodule

// File: tb/tb_braille_round_ctrl.sv
// tb/tb_braille_round_ctrl.sv - Self-checking bench for braille_round_ctrl
`define CHK(tag, obs, expv) \
    begin \
        n_checks++; \
        assert (32'(obs) === 32'(expv)) else begin \
            n_fail++; \
            $error("FAIL %s observed=%0d expected=%0d", tag, 32'(obs), 32'(expv)); \
        end \
    end

module tb_braille_round_ctrl;

    localparam int ROUNDS      = 2;
    localparam int MAX_TRIES   = 3;
    localparam int TIMEOUT_CYC = 8;
    localparam int CHECK_WIN   = 3;
`ifdef BRAILLE_HINT_EN
    localparam bit HINT_EN = 1'b1;
`else
    localparam bit HINT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic       rng_req;
    logic       rng_ack;
    logic [3:0] rng_letter;
    logic       player_valid;
    logic [3:0] target;
    logic       cmp_valid;
    logic       match_pulse;
    logic       seg_en;
    logic [7:0] score;
    logic [7:0] round_no;
    logic [2:0] tries_left;
    logic       hit;
    logic       miss;
    logic       game_over;
    logic       hint;

    int n_checks = 0;
    int n_fail   = 0;

    int         exp_score;
    int         exp_round;
    int         exp_tries;
    logic [3:0] exp_target;

    braille_round_ctrl #(
        .ROUNDS      (ROUNDS),
        .MAX_TRIES   (MAX_TRIES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CHECK_WIN   (CHECK_WIN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rng_req      (rng_req),
        .rng_ack      (rng_ack),
        .rng_letter   (rng_letter),
        .player_valid (player_valid),
        .target       (target),
        .cmp_valid    (cmp_valid),
        .match_pulse  (match_pulse),
        .seg_en       (seg_en),
        .score        (score),
        .round_no     (round_no),
        .tries_left   (tries_left),
        .hit          (hit),
        .miss         (miss),
        .game_over    (game_over),
        .hint
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic exp_hint();
        return HINT_EN && (exp_tries == 1);
    endfunction

    task automatic slot();
        @(negedge clk);
        player_valid = 1'b0;
        match_pulse  = 1'b0;
        rng_ack      = 1'b0;
    endtask

    task automatic start_game();
        start = 1'b1;
        #1;
        slot();
        start     = 1'b0;
        exp_score = 0;
        exp_round = 1;
        #1;
        `CHK("start_score", score, 0)
        `CHK("start_round", round_no, 1)
        `CHK("start_over", game_over, 1'b0)
    endtask

    task automatic do_fetch(input logic [3:0] letter, input int d);
        for (int i = 0; i <= d; i++) begin
            player_valid = 1'($urandom_range(0, 1));
            match_pulse  = 1'($urandom_range(0, 1));
            if (i == d) begin
                rng_ack    = 1'b1;
                rng_letter = letter;
            end
            #1;
            `CHK("fetch_req", rng_req, (i == 0))
            `CHK("fetch_hit", hit, 1'b0)
            `CHK("fetch_cmp", cmp_valid, 1'b0)
            n_checks++;
            if (game_over !== 1'b0) begin
                n_fail++;
                $error("FAIL fetch_over_inline observed=%0d", game_over);
            end
            slot();
        end
        exp_target = letter;
        exp_tries  = MAX_TRIES;
        #1;
        `CHK("fetch_target", target, exp_target)
        `CHK("fetch_tries", tries_left, exp_tries)
        `CHK("win_seg_en", seg_en, 1'b1)
        `CHK("win_cmp", cmp_valid, 1'b0)
    endtask

    task automatic run_entry(input int p, input int m, output int res);
        int wait_n;
        bit got_hit;
        wait_n = (p < TIMEOUT_CYC) ? p : TIMEOUT_CYC;
        for (int i = 0; i < wait_n; i++) begin
            rng_ack     = 1'($urandom_range(0, 1));
            rng_letter  = 4'($urandom_range(0, 15));
            match_pulse = 1'($urandom_range(0, 1));
            #1;
            `CHK("wait_cmp", cmp_valid, 1'b0)
            `CHK("wait_miss", miss, 1'b0)
            `CHK("wait_hit", hit, 1'b0)
            `CHK("wait_target", target, exp_target)
            `CHK("wait_hint", hint, exp_hint())
            `CHK("wait_over", game_over, 1'b0)
            n_checks++;
            if (target !== exp_target) begin
                n_fail++;
                $error("FAIL wait_target_inline observed=%0d expected=%0d", target, exp_target);
            end
            slot();
        end
        got_hit = 1'b0;
        if (p < TIMEOUT_CYC) begin
            player_valid = 1'b1;
            #1;
            `CHK("entry_miss", miss, 1'b0)
            `CHK("entry_hint", hint, exp_hint())
            slot();
            for (int k = 0; k <= CHECK_WIN && !got_hit; k++) begin
                if (k > 0) player_valid = 1'($urandom_range(0, 1));
                if (k == m) match_pulse = 1'b1;
                #1;
                `CHK("cmp_valid", cmp_valid, (k == 0))
                `CHK("check_hit", hit, (k == m))
                `CHK("check_miss", miss, 1'b0)
                `CHK("check_hint", hint, exp_hint())
                n_checks++;
                if (hit !== (k == m)) begin
                    n_fail++;
                    $error("FAIL check_hit_inline observed=%0d k=%0d m=%0d", hit, k, m);
                end
                got_hit = (k == m);
                slot();
            end
            if (!got_hit && m == CHECK_WIN + 1) match_pulse = 1'b1;
        end
        if (got_hit) begin
            exp_score = (exp_score >= 255) ? 255 : exp_score + 1;
            res = 1;
        end else begin
            #1;
            `CHK("miss_pulse", miss, 1'b1)
            `CHK("miss_no_hit", hit, 1'b0)
            `CHK("miss_tries", tries_left, exp_tries)
            exp_tries--;
            slot();
            #1;
            `CHK("tries_dec", tries_left, exp_tries)
            `CHK("miss_once", miss, 1'b0)
            `CHK("miss_score", score, exp_score)
            res = (exp_tries == 0) ? 2 : 0;
        end
    endtask

    task automatic finish_round();
        #1;
        `CHK("next_score", score, exp_score)
        `CHK("next_tries", tries_left, exp_tries)
        `CHK("next_hit", hit, 1'b0)
        `CHK("next_round", round_no, exp_round)
        `CHK("next_req", rng_req, 1'b0)
        slot();
        #1;
        if (exp_round == ROUNDS) begin
            `CHK("done_over", game_over, 1'b1)
            `CHK("done_seg", seg_en, 1'b1)
            `CHK("done_score", score, exp_score)
            `CHK("done_req", rng_req, 1'b0)
        end else begin
            exp_round++;
            `CHK("fetch_round", round_no, exp_round)
            `CHK("fetch_over", game_over, 1'b0)
        end
    endtask

    task automatic play_round(input bit force_miss);
        int res;
        int p;
        int m;
        do_fetch(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        res = 0;
        while (res == 0) begin
            p = int'($urandom_range(0, TIMEOUT_CYC));
            m = force_miss ? CHECK_WIN + 1 : int'($urandom_range(0, CHECK_WIN + 1));
            run_entry(p, m, res);
        end
        finish_round();
    endtask

    initial begin
        int res;
        rst          = 1'b0;
        start        = 1'b0;
        rng_ack      = 1'b0;
        rng_letter   = 4'd0;
        player_valid = 1'b0;
        match_pulse  = 1'b0;
        exp_score    = 0;
        exp_round    = 0;
        exp_tries    = 0;
        exp_target   = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        `CHK("rst_round", round_no, 0)
        `CHK("rst_score", score, 0)
        `CHK("rst_target", target, 0)
        `CHK("rst_tries", tries_left, 0)
        `CHK("rst_seg", seg_en, 1'b0)
        `CHK("rst_over", game_over, 1'b0)
        `CHK("rst_req", rng_req, 1'b0)
        `CHK("rst_hint", hint, 1'b0)

        for (int i = 0; i < 3; i++) begin
            slot();
            rng_ack      = 1'b1;
            player_valid = 1'b1;
            match_pulse  = 1'b1;
            #1;
            `CHK("idle_round", round_no, 0)
            `CHK("idle_seg", seg_en, 1'b0)
            `CHK("idle_req", rng_req, 1'b0)
            `CHK("idle_hit", hit, 1'b0)
            n_checks++;
            if (round_no !== 8'd0) begin
                n_fail++;
                $error("FAIL idle_round_inline observed=%0d", round_no);
            end
        end
        slot();

        start_game();
        do_fetch(4'd5, 0);
        run_entry(2, 2, res);
        finish_round();
        do_fetch(4'd9, 1);
        run_entry(1, CHECK_WIN + 1, res);
        run_entry(TIMEOUT_CYC, 0, res);
        run_entry(TIMEOUT_CYC - 1, CHECK_WIN, res);
        finish_round();
        for (int i = 0; i < 3; i++) begin
            slot();
            #1;
            `CHK("done_hold_score", score, 2)
            `CHK("done_hold_over", game_over, 1'b1)
            n_checks++;
            if (score !== 8'd2) begin
                n_fail++;
                $error("FAIL done_hold_score_inline observed=%0d", score);
            end
        end

        start_game();
        play_round(1'b1);
        play_round(1'b0);

        for (int g = 0; g < 6; g++) begin
            start_game();
            for (int r = 0; r < ROUNDS; r++) begin
                play_round(1'b0);
            end
        end

        start_game();
        do_fetch(4'hA, 1);
        player_valid = 1'b1;
        slot();
        rst = 1'b0;
        #1;
        `CHK("pre_rst_cmp", cmp_valid, 1'b1)
        slot();
        rst = 1'b1;
        #1;
        `CHK("mid_rst_round", round_no, 0)
        `CHK("mid_rst_score", score, 0)
        `CHK("mid_rst_hit", hit, 1'b0)
        `CHK("mid_rst_miss", miss, 1'b0)
        `CHK("mid_rst_seg", seg_en, 1'b0)
        `CHK("mid_rst_target", target, 0)
        `CHK("mid_rst_cmp", cmp_valid, 1'b0)
        n_checks++;
        if (score !== 8'd0) begin
            n_fail++;
            $error("FAIL mid_rst_score_inline observed=%0d", score);
        end
        slot();
        #1;
        `CHK("post_rst_round", round_no, 0)
        `CHK("post_rst_req", rng_req, 1'b0)
        `CHK("post_rst_miss", miss, 1'b0)

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/braille_round_ctrl.md
Name: braille_round_ctrl

Overview:
- Round sequencer for the Braille trainer game; sits between the random-letter generator, the player input encoder, the match comparator and the score/7-segment display.
- Fetches a target letter, gates player entries into the comparator, interprets the comparator's one-cycle match pulse, and enforces tries per round and a per-entry timeout.
- Tracks score and round count; ends the game after ROUNDS rounds.

Parameters:
- ROUNDS, 10, rounds per game (1..255).
- MAX_TRIES, 3, wrong entries allowed per round before it is forfeited (1..7).
- TIMEOUT_CYC, 500000, clock cycles allowed per entry before it counts as a miss (>=4).
- CHECK_WIN, 3, cycles to wait for the comparator match pulse after forwarding an entry (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  level; sampled in IDLE/DONE to begin a game
- rng_req  out  1  one-cycle request for a new random letter
- rng_ack  in  1  rng_letter valid this cycle
- rng_letter  in  4  random letter code
- player_valid  in  1  one-cycle pulse: player entry ready
- target  out  4  latched letter driven to comparator and display
- cmp_valid  out  1  one-cycle strobe forwarding player entry to comparator
- match_pulse  in  1  comparator hit pulse
- seg_en  out  1  display enable for target/score
- score  out  8  correct rounds this game
- round_no  out  8  current round, 1-based; 0 when idle
- tries_left  out  3  remaining tries in the current round
- hit  out  1  one-cycle pulse on a correct round
- miss  out  1  one-cycle pulse on each wrong or timed-out entry
- game_over  out  1  high in DONE
- hint  out  1  see Optional Feature

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all outputs 0; target=0; internal counters 0. Reset mid-game abandons the game immediately; no pulses are emitted.
- IDLE: seg_en=0. When start=1: score:=0, round_no:=1, go to FETCH.
- FETCH: rng_req=1 in the first cycle only, then wait. On rng_ack: target:=rng_letter, tries_left:=MAX_TRIES, timer:=0, go to WAIT_IN. rng_ack outside FETCH is ignored.
- WAIT_IN: seg_en=1; timer increments each cycle.
  - player_valid: cmp_valid=1 in the next cycle (registered), window counter:=0, go to CHECK.
  - timer==TIMEOUT_CYC-1 with no player_valid: treated as a wrong entry (MISS path).
  - player_valid wins if both occur in the same cycle.
- CHECK: player_valid is ignored.
  - match_pulse within CHECK_WIN cycles of cmp_valid: hit pulse, score:=score+1 (saturates at 255), go to NEXT.
  - Window expires: go to MISS path.
- MISS path: one-cycle miss pulse; tries_left decrements. If the result is 0 go to NEXT; else timer:=0 and go back to WAIT_IN.
- NEXT (1 cycle): if round_no==ROUNDS go to DONE; else round_no increments and go to FETCH.
- DONE: game_over=1, seg_en=1, score held. start=1 clears score, sets round_no:=1 and goes to FETCH. start held high therefore restarts every game.
- Latencies:
  - player_valid to cmp_valid: 1 cycle.
  - Hit decision: at most CHECK_WIN cycles after cmp_valid.
  - Hit to next rng_req: 2 cycles.
- Stray match_pulse outside CHECK: ignored.

Optional Feature:
- Macro BRAILLE_HINT_EN.
- Defined: hint=1 while in WAIT_IN/CHECK with tries_left==1, so the display can show the target's dot pattern.
- Undefined: hint is tied to 0 and no extra logic is built.

Decomposition:
- Shared package braille_pkg holds:
  - Letter code width constant, LETTER_W=4.
  - State enum: IDLE, FETCH, WAIT_IN, CHECK, MISS, NEXT, DONE.
  - Default parameter constants.
- Natural sub-module: braille_entry_timer, a loadable down-counter with a timeout flag. Used for both the entry timeout and the check window.

Test Plan:
- Reset mid-CHECK (rst=0 for 1 cycle) -> next cycle: state IDLE, score=0, round_no=0, no hit/miss pulses.
- start; rng_ack with letter 5; player_valid; match_pulse 2 cycles after cmp_valid -> hit=1 once, score=1, round_no=2, rng_req 2 cycles after hit.
- MAX_TRIES=3, three entries with no match_pulse -> miss pulses 3 times, tries_left 3→2→1→0, score unchanged, round advances.
- TIMEOUT_CYC=8, no player_valid -> miss asserted 8 cycles after entering WAIT_IN, tries_left decrements.
- ROUNDS=2, both rounds hit -> game_over=1, score=2; start=1 -> score=0, round_no=1, rng_req pulses.
- player_valid and timeout in the same cycle -> entry processed (cmp_valid=1), no miss; with BRAILLE_HINT_EN, hint=1 once tries_left==1.
